// File: rtl/pc_fetch_unit_pkg.sv
// Shared processor definitions for the fetch stage: datapath widths, special
// instruction encodings and the fetch FSM state type.
package pc_fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;
  localparam logic [INSTR_W-1:0] NOP_INSTR  = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage : pc_fetch_unit_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush loads a bubble and wins over hold; hold
// freezes the current contents; otherwise the new fetch is captured.
module if_id_reg #(
  parameter int                 PC_W      = pc_fetch_unit_pkg::PC_W,
  parameter int                 INSTR_W   = pc_fetch_unit_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pc_fetch_unit_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               valid_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation ordering cannot change the result.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= valid_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, RUN/HALTED fetch
// FSM and the IF/ID pipeline register. Instruction memory is combinational.
module pc_fetch_unit
  import pc_fetch_unit_pkg::fetch_state_e;
  import pc_fetch_unit_pkg::RUN;
  import pc_fetch_unit_pkg::HALTED;
#(
  parameter int                 PC_W       = pc_fetch_unit_pkg::PC_W,
  parameter int                 INSTR_W    = pc_fetch_unit_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = pc_fetch_unit_pkg::HALT_INSTR,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = pc_fetch_unit_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    PCnew,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    PC_IF_ID,
  output logic [INSTR_W-1:0] instr_IF_ID,
  output logic               valid_IF_ID,
  output logic               halted
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            is_halt_instr;
  logic            ifid_hold;
  logic            ifid_flush;

  assign is_halt_instr = (instr_in == HALT_INSTR);

  // State register: PC and fetch FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Next-state / next-PC. Priority: branch redirect, then stall, then fetch.
  // NOTE: every combinational output gets a default first so no path through
  // the if/case tree leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (branch_taken) begin
      state_d = RUN;
      pc_d    = PCnew;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          if (is_halt_instr) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Outputs decoded from registered state and the current control inputs.
  always_comb begin
    halted     = (state_q == HALTED);
    ifid_hold  = stall;
    ifid_flush = branch_taken || ((state_q == HALTED) && !stall);
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (ifid_hold),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .instr_i (instr_in),
    .valid_i (1'b1),
    .pc_o    (PC_IF_ID),
    .instr_o (instr_IF_ID),
    .valid_o (valid_IF_ID)
  );

  assign imem_addr = pc_q;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a cycle model pushes expected outputs
// to a scoreboard queue, plus directed checks of the key fetch scenarios.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  PCnew;
  logic [15:0] instr_in;
  logic [7:0]  imem_addr;
  logic [7:0]  PC_IF_ID;
  logic [15:0] instr_IF_ID;
  logic        valid_IF_ID;
  logic        halted;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .PCnew        (PCnew),
    .instr_in     (instr_in),
    .imem_addr    (imem_addr),
    .PC_IF_ID     (PC_IF_ID),
    .instr_IF_ID  (instr_IF_ID),
    .valid_IF_ID  (valid_IF_ID),
    .halted       (halted)
  );

  // Combinational instruction memory.
  logic [15:0] mem [256];
  assign instr_in = mem[imem_addr];

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_pc;
  logic        m_halted;
  logic [7:0]  m_ipc;
  logic [15:0] m_ins;
  logic        m_val;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, push expectation, then pop
  // and compare once the DUT has updated.
  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] t);
    exp_t        e;
    logic [15:0] ins;
    rst          = r;
    stall        = s;
    branch_taken = b;
    PCnew        = t;
    ins = mem[m_pc];
    if (r) begin
      m_pc = 8'h00; m_halted = 1'b0; m_ipc = 8'h00; m_ins = 16'h0000; m_val = 1'b0;
    end else if (b) begin
      m_pc = t; m_halted = 1'b0; m_ipc = 8'h00; m_ins = 16'h0000; m_val = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (!m_halted) begin
      m_ipc = m_pc; m_ins = ins; m_val = 1'b1;
      if (ins == 16'hFFFF) m_halted = 1'b1;
      else                 m_pc = m_pc + 8'd1;
    end else begin
      m_ipc = 8'h00; m_ins = 16'h0000; m_val = 1'b0;
    end
    e.addr = m_pc; e.pc = m_ipc; e.instr = m_ins; e.valid = m_val; e.halted = m_halted;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("sb_addr",   32'(imem_addr),   32'(e.addr));
      check("sb_ifpc",   32'(PC_IF_ID),    32'(e.pc));
      check("sb_instr",  32'(instr_IF_ID), 32'(e.instr));
      check("sb_valid",  32'(valid_IF_ID), 32'(e.valid));
      check("sb_halted", 32'(halted),      32'(e.halted));
    end
  endtask

  logic [15:0] tbl [3];

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; PCnew = 8'h00;
    m_pc = 8'h00; m_halted = 1'b0; m_ipc = 8'h00; m_ins = 16'h0000; m_val = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[8'h30] = 16'hFFFF;
    tbl[0] = 16'h1111; tbl[1] = 16'h2222; tbl[2] = 16'h3333;
    @(posedge clk);
    #1;

    // Reset overrides a simultaneous stall and branch.
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check("rst_addr",   32'(imem_addr),   32'h00);
    check("rst_valid",  32'(valid_IF_ID), 32'h0);
    check("rst_halted", 32'(halted),      32'h0);
    check("rst_instr",  32'(instr_IF_ID), 32'h0000);

    // Sequential fetch from reset.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("seq_addr",  32'(imem_addr),   32'(i + 1));
      check("seq_ifpc",  32'(PC_IF_ID),    32'(i));
      check("seq_instr", 32'(instr_IF_ID), 32'(tbl[i]));
      check("seq_valid", 32'(valid_IF_ID), 32'h1);
    end

    // PC wrap 8'hFF -> 8'h00.
    step(1'b0, 1'b0, 1'b1, 8'hFE);
    check("br_addr",  32'(imem_addr),   32'hFE);
    check("br_valid", 32'(valid_IF_ID), 32'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("wrap_addr0", 32'(imem_addr), 32'hFF);
    check("wrap_ifpc0", 32'(PC_IF_ID),  32'hFE);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("wrap_addr1", 32'(imem_addr), 32'h00);
    check("wrap_ifpc1", 32'(PC_IF_ID),  32'hFF);

    // Stall holds PC and IF/ID.
    step(1'b0, 1'b0, 1'b1, 8'h0F);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("stall_addr",  32'(imem_addr),   32'h10);
      check("stall_ifpc",  32'(PC_IF_ID),    32'h0F);
      check("stall_instr", 32'(instr_IF_ID), 32'hA50F);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("unstall_ifpc", 32'(PC_IF_ID),  32'h10);
    check("unstall_addr", 32'(imem_addr), 32'h11);

    // Branch wins over stall.
    step(1'b0, 1'b0, 1'b1, 8'h1F);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h05);
    check("brst_addr",  32'(imem_addr),   32'h05);
    check("brst_valid", 32'(valid_IF_ID), 32'h0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("brst_ifpc", 32'(PC_IF_ID), 32'h05);

    // Halt detection, bubble, then branch out of HALTED.
    step(1'b0, 1'b0, 1'b1, 8'h2F);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("halt_ifpc",   32'(PC_IF_ID),    32'h30);
    check("halt_instr",  32'(instr_IF_ID), 32'hFFFF);
    check("halt_valid",  32'(valid_IF_ID), 32'h1);
    check("halt_halted", 32'(halted),      32'h1);
    check("halt_addr",   32'(imem_addr),   32'h30);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("hbub_valid", 32'(valid_IF_ID), 32'h0);
    check("hbub_addr",  32'(imem_addr),   32'h30);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    check("hbr_halted", 32'(halted),    32'h0);
    check("hbr_addr",   32'(imem_addr), 32'h40);

    // Stall while HALTED holds IF/ID; reset with stall leaves HALTED.
    step(1'b0, 1'b0, 1'b1, 8'h30);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("hst_halted", 32'(halted),      32'h1);
    check("hst_valid",  32'(valid_IF_ID), 32'h1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("hrst_addr",   32'(imem_addr),   32'h00);
    check("hrst_halted", 32'(halted),      32'h0);
    check("hrst_valid",  32'(valid_IF_ID), 32'h0);

    // Random control traffic against the model.
    for (int i = 0; i < 80; i++) begin
      step(($urandom % 25) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
           8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pc_fetch_unit

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter PC_W, 8, PC and branch-target width.
REQ-002 Parameter INSTR_W, 16, instruction width.
REQ-003 Parameter RESET_PC, 8'h00, PC value after reset.
REQ-004 Parameter HALT_INSTR, 16'hFFFF, encoding that stops fetch.
REQ-005 Parameter NOP_INSTR, 16'h0000, bubble encoding placed in IF/ID.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 stall  in  1  hazard-unit hold request for PC and IF/ID.
REQ-009 branch_taken  in  1  EX-stage branch resolved taken; redirects and flushes.
REQ-010 PCnew  in  PC_W  branch target from EX-stage PC calculation (PC_ID_EX + relAdd_IDEX).
REQ-011 instr_in  in  INSTR_W  instruction memory read data at imem_addr, same cycle (combinational memory).
REQ-012 imem_addr  out  PC_W  current PC, driven directly from PC register.
REQ-013 PC_IF_ID  out  PC_W  PC of instruction held in IF/ID.
REQ-014 instr_IF_ID  out  INSTR_W  instruction held in IF/ID.
REQ-015 valid_IF_ID  out  1  IF/ID holds a real instruction (0 = bubble).
REQ-016 halted  out  1  fetch FSM in HALTED state.

Function
REQ-017 FSM states SHALL be RUN and HALTED; update priority per cycle: rst > branch_taken > stall > halt detection > normal fetch.
REQ-018 branch_taken=1 (any state, stall ignored): PC <= PCnew; IF/ID <= {0, NOP_INSTR, valid 0}; state <= RUN.
REQ-019 stall=1, branch_taken=0: PC, IF/ID, and state SHALL all hold unchanged.
REQ-020 RUN, no stall/branch, instr_in != HALT_INSTR: IF/ID <= {PC, instr_in, 1}; PC <= PC+1 modulo 2^PC_W (8'hFF wraps to 8'h00, no carry out).
REQ-021 RUN, no stall/branch, instr_in == HALT_INSTR: IF/ID <= {PC, HALT_INSTR, 1}; PC holds; state <= HALTED.
REQ-022 HALTED, no stall/branch: PC holds; IF/ID <= bubble {0, NOP_INSTR, 0}; state stays HALTED.
REQ-023 halted SHALL equal (state == HALTED), registered, no combinational path from inputs.
REQ-024 Fetch latency: instruction at PC p appears on instr_IF_ID one cycle after p is on imem_addr, absent stall.
REQ-025 Branch redirect latency: PCnew appears on imem_addr the cycle after branch_taken is sampled high.
REQ-026 Outputs imem_addr, IF/ID fields, halted SHALL be purely registered.

Reset
REQ-027 On rst=1 at a clock edge: PC <= RESET_PC, PC_IF_ID <= 0, instr_IF_ID <= NOP_INSTR, valid_IF_ID <= 0, state <= RUN, halted <= 0.
REQ-028 rst SHALL override stall and branch_taken in the same cycle; reset mid-HALTED returns to RUN.
REQ-029 No asynchronous reset path; outputs undefined only before first reset edge.

Structure
REQ-030 PC_W, INSTR_W, NOP_INSTR, HALT_INSTR, and FSM state encoding (1-bit enum RUN=0, HALTED=1) SHALL live in the shared processor package.
REQ-031 One sub-module, if_id_reg (IF/ID pipeline register with hold and flush inputs), SHALL be instantiated; PC register, incrementer, next-PC mux and FSM stay in pc_fetch_unit.

Verification
REQ-032 Reset then 3 free cycles, imem returns 16'h1111/2222/3333 at addr 0/1/2 -> imem_addr 0,1,2,3; IF/ID PCs 0,1,2 with matching instr, valid 1.
REQ-033 PC=8'hFE, two free fetches -> imem_addr 8'hFF then 8'h00; PC_IF_ID 8'hFE then 8'hFF.
REQ-034 PC=8'h10, stall=1 two cycles -> imem_addr stays 8'h10, IF/ID unchanged; release -> IF/ID PC 8'h10, imem_addr 8'h11.
REQ-035 PC=8'h20, stall=1 and branch_taken=1 with PCnew=8'h05 same cycle -> next imem_addr 8'h05, valid_IF_ID 0; following cycle PC_IF_ID 8'h05.
REQ-036 instr_in=16'hFFFF at PC 8'h30 -> IF/ID {8'h30, FFFF, 1}, halted 1, PC held 8'h30, next IF/ID bubble; then branch_taken PCnew=8'h40 -> halted 0, imem_addr 8'h40.
REQ-037 rst asserted while HALTED with stall=1 -> next cycle imem_addr RESET_PC, halted 0, valid_IF_ID 0.
